// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and constants for the instruction-cache refill controller.
package icache_refill_ctrl_pkg;
  localparam logic [31:0] ZeroWord  = 32'h0;
  localparam int          InstBytes = 4;

  typedef logic [31:0] InstAddrBus;
  typedef logic [31:0] InstBus;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } state_t;
endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Fetch-side, memory-arbiter and cache-fill signals of the refill controller.
// master = controller, slave = surrounding IF stage / arbiter / cache.
interface icache_refill_ctrl_if
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic              miss_i;
  logic [ADDR_W-1:0] miss_pc_i;
  logic              flush_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic [7:0]        mem_din_i;
  logic              we_o;
  logic [ADDR_W-1:0] wpc_o;
  InstBus            winst_o;
  logic              done_o;
  InstBus            inst_o;

  modport master (
    input  miss_i, miss_pc_i, flush_i, mem_gnt_i, mem_din_i,
    output mem_req_o, mem_addr_o, we_o, wpc_o, winst_o, done_o, inst_o
  );

  modport slave (
    output miss_i, miss_pc_i, flush_i, mem_gnt_i, mem_din_i,
    input  mem_req_o, mem_addr_o, we_o, wpc_o, winst_o, done_o, inst_o
  );
endinterface

// File: rtl/icache_refill_ctrl_refill_byte_assembler.sv
// Collects returned bytes into a little-endian word; byte idx k lands in bits 8k+7:8k.
module refill_byte_assembler #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   en,
  input  logic [CNT_W-1:0]       idx,
  input  logic [7:0]             din,
  output logic [NUM_LANES*8-1:0] word
);
  logic [NUM_LANES-1:0][7:0] lane;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane <= '0;
    end else if (en) begin
      for (int k = 0; k < NUM_LANES; k++)
        if (idx == CNT_W'(k)) lane[k] <= din;
    end
  end

  assign word = lane;
endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill: byte-wise memory reads, word assembly, one-cycle fill write.
// Optional ICACHE_REFILL_STATS_EN adds refill and stall counters.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int INST_BYTES = InstBytes,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  icache_refill_ctrl_if.master bus
`ifdef ICACHE_REFILL_STATS_EN
  ,
  output logic [31:0] refill_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);
  localparam logic [CNT_W-1:0] NumBytes = CNT_W'(INST_BYTES);
  localparam logic [CNT_W-1:0] LastIdx  = CNT_W'(INST_BYTES - 1);

  state_t                  state, state_nxt;
  logic [ADDR_W-1:0]       base;
  logic [CNT_W-1:0]        issued, recv;
  logic                    pending;
  logic [INST_BYTES*8-1:0] word;
  logic                    start, req, fire, take, last;

  // rdy gates every state change, so a frozen cycle can neither issue nor capture
  assign start = rdy && state == IDLE && bus.miss_i && !bus.flush_i;
  assign req   = rdy && state == FETCH && issued < NumBytes;
  assign fire  = req && bus.mem_gnt_i;
  assign take  = rdy && state == FETCH && pending && !bus.flush_i;
  assign last  = take && recv == LastIdx;

  always_ff @(posedge clk) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.miss_i) state_nxt = FETCH;
        FETCH:   if (last) state_nxt = WRITE;
        WRITE:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base    <= '0;
      issued  <= '0;
      recv    <= '0;
      pending <= 1'b0;
    end else if (rdy) begin
      if (bus.flush_i) begin
        // a byte granted now still returns next cycle; dropping pending discards it
        issued  <= '0;
        recv    <= '0;
        pending <= 1'b0;
      end else if (start) begin
        base    <= bus.miss_pc_i;
        issued  <= '0;
        recv    <= '0;
        pending <= 1'b0;
      end else begin
        pending <= fire;
        if (fire) issued <= issued + CNT_W'(1);
        if (take) recv   <= recv + CNT_W'(1);
      end
    end
  end

  refill_byte_assembler #(
    .NUM_LANES (INST_BYTES),
    .CNT_W     (CNT_W)
  ) u_asm (
    .clk   (clk),
    .rst   (rst),
    .clear (rdy && (bus.flush_i || start)),
    .en    (take),
    .idx   (recv),
    .din   (bus.mem_din_i),
    .word  (word)
  );

  always_comb begin
    bus.mem_req_o  = req;
    bus.mem_addr_o = '0;
    bus.we_o       = 1'b0;
    bus.done_o     = 1'b0;
    bus.wpc_o      = '0;
    bus.winst_o    = ZeroWord;
    bus.inst_o     = ZeroWord;
    case (state)
      FETCH: bus.mem_addr_o = base + ADDR_W'(issued);
      WRITE: begin
        bus.we_o    = rdy && !bus.flush_i;
        bus.done_o  = rdy && !bus.flush_i;
        bus.wpc_o   = base;
        bus.winst_o = word;
        bus.inst_o  = word;
      end
      default: ;
    endcase
  end

`ifdef ICACHE_REFILL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      refill_cnt_o <= '0;
      stall_cnt_o  <= '0;
    end else begin
      if (bus.we_o) refill_cnt_o <= refill_cnt_o + 32'd1;
      if (state == FETCH && req && !bus.mem_gnt_i) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: inputs change on negedge, outputs sampled 1ns later.
module tb_icache_refill_ctrl;
  logic clk, rst, rdy;
  int   errors = 0;
  int   checks = 0;

  icache_refill_ctrl_if #(.ADDR_W(32)) bus ();

`ifdef ICACHE_REFILL_STATS_EN
  logic [31:0] refill_cnt, stall_cnt;
`endif

  icache_refill_ctrl #(.ADDR_W(32), .INST_BYTES(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
`ifdef ICACHE_REFILL_STATS_EN
    ,
    .refill_cnt_o (refill_cnt),
    .stall_cnt_o  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 8'h13;
      32'h0000_1001: return 8'h05;
      32'h0000_1002: return 8'h10;
      32'h0000_1003: return 8'h00;
      32'h0000_2000: return 8'h93;
      32'h0000_2001: return 8'h00;
      32'h0000_2002: return 8'h50;
      32'h0000_2003: return 8'h00;
      32'hFFFF_FFFE: return 8'hB7;
      32'hFFFF_FFFF: return 8'h12;
      32'h0000_0000: return 8'h34;
      32'h0000_0001: return 8'h56;
      default:       return 8'hEE;
    endcase
  endfunction

  // arbiter/memory model: data appears the cycle after a grant and is held otherwise
  always @(posedge clk) begin
    if (rst) bus.mem_din_i <= 8'h00;
    else if (bus.mem_req_o && bus.mem_gnt_i) bus.mem_din_i <= mem_byte(bus.mem_addr_o);
  end

  // Stimulus helper: raises miss at the current negedge, applies grant/rdy-low windows
  // by cycle index, and reports the cycle count to done_o (-1 on timeout).
  task automatic run_refill(input logic [31:0] pc, input int g_lo, input int g_hi,
                            input int r_lo, input int r_hi, input int max_cyc,
                            output int cyc, output logic [31:0] inst, output logic [31:0] winst,
                            output logic [31:0] wpc, output logic req_rdy_low);
    bus.miss_pc_i = pc;
    bus.miss_i    = 1'b1;
    cyc = -1; inst = '0; winst = '0; wpc = '0; req_rdy_low = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      bus.mem_gnt_i = !(k >= g_lo && k <= g_hi);
      rdy           = !(k >= r_lo && k <= r_hi);
      #1;
      if (!rdy && bus.mem_req_o) req_rdy_low = 1'b1;
      if (bus.done_o) begin
        cyc = k + 1; inst = bus.inst_o; winst = bus.winst_o; wpc = bus.wpc_o;
        break;
      end
      @(negedge clk);
    end
    bus.miss_i = 1'b0; bus.mem_gnt_i = 1'b1; rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.mem_req_o); end
    checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr_o); end
    checks++; if ({bus.we_o, bus.done_o} !== 2'b00) begin errors++; $display("FAIL reset_we_done got=%b exp=00", {bus.we_o, bus.done_o}); end
    checks++; if ({bus.wpc_o, bus.winst_o, bus.inst_o} !== 96'h0) begin errors++; $display("FAIL reset_fill got=%h/%h/%h exp=0", bus.wpc_o, bus.winst_o, bus.inst_o); end
`ifdef ICACHE_REFILL_STATS_EN
    checks++; if ({refill_cnt, stall_cnt} !== 64'h0) begin errors++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", refill_cnt, stall_cnt); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_continuous();
    bus.miss_pc_i = 32'h1000;
    bus.miss_i    = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      #1;
      if (k >= 1 && k <= 4) begin
        checks++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h1000 + 32'(k - 1)) begin
          errors++; $display("FAIL cont_issue k=%0d got req=%b addr=%h exp req=1 addr=%h", k, bus.mem_req_o, bus.mem_addr_o, 32'h1000 + 32'(k - 1));
        end
      end
      if (k == 5) begin
        checks++; if (bus.mem_req_o !== 1'b0 || bus.done_o !== 1'b0) begin errors++; $display("FAIL cont_k5 got req=%b done=%b exp 0/0", bus.mem_req_o, bus.done_o); end
      end
      if (k == 6) begin
        checks++; if (bus.we_o !== 1'b1 || bus.done_o !== 1'b1) begin errors++; $display("FAIL cont_pulse got we=%b done=%b exp 1/1", bus.we_o, bus.done_o); end
        checks++; if (bus.wpc_o !== 32'h1000) begin errors++; $display("FAIL cont_wpc got=%h exp=00001000", bus.wpc_o); end
        checks++; if (bus.winst_o !== 32'h00100513 || bus.inst_o !== 32'h00100513) begin errors++; $display("FAIL cont_word got winst=%h inst=%h exp=00100513", bus.winst_o, bus.inst_o); end
      end
      if (k < 6) @(negedge clk);
    end
    bus.miss_i = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.we_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL cont_after got we=%b req=%b exp 0/0", bus.we_o, bus.mem_req_o); end
    @(negedge clk);
  endtask

  task automatic test_grant_gap();
    int cyc; logic [31:0] inst, winst, wpc; logic rl;
`ifdef ICACHE_REFILL_STATS_EN
    logic [31:0] st0, rf0;
    st0 = stall_cnt; rf0 = refill_cnt;
`endif
    run_refill(32'h1000, 2, 4, -1, -1, 30, cyc, inst, winst, wpc, rl);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL gap_latency got=%0d exp=10", cyc); end
    checks++; if (inst !== 32'h00100513 || winst !== 32'h00100513 || wpc !== 32'h1000) begin errors++; $display("FAIL gap_word got inst=%h winst=%h wpc=%h exp 00100513/00100513/00001000", inst, winst, wpc); end
`ifdef ICACHE_REFILL_STATS_EN
    checks++; if (stall_cnt - st0 !== 32'd3) begin errors++; $display("FAIL gap_stalls got=%0d exp=3", stall_cnt - st0); end
    checks++; if (refill_cnt - rf0 !== 32'd1) begin errors++; $display("FAIL gap_refills got=%0d exp=1", refill_cnt - rf0); end
`endif
  endtask

  task automatic test_rdy_stall();
    int cyc; logic [31:0] inst, winst, wpc; logic rl;
    run_refill(32'h1000, -1, -1, 2, 3, 30, cyc, inst, winst, wpc, rl);
    checks++; if (rl !== 1'b0) begin errors++; $display("FAIL rdy_req_low got=%b exp=0", rl); end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL rdy_latency got=%0d exp=9", cyc); end
    checks++; if (inst !== 32'h00100513 || wpc !== 32'h1000) begin errors++; $display("FAIL rdy_word got inst=%h wpc=%h exp 00100513/00001000", inst, wpc); end
  endtask

  task automatic test_flush_fetch();
    int we_k = -1; logic [31:0] wpc = '0, inst = '0;
    bus.miss_pc_i = 32'h1000;
    bus.miss_i    = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 3) bus.flush_i = 1'b1;
      if (k == 4) begin bus.flush_i = 1'b0; bus.miss_pc_i = 32'h2000; end
      #1;
      if (k == 4) begin
        checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL flush_idle_req got=%b exp=0", bus.mem_req_o); end
      end
      if (k == 5) begin
        checks++; if (bus.mem_addr_o !== 32'h2000) begin errors++; $display("FAIL flush_new_addr got=%h exp=00002000", bus.mem_addr_o); end
      end
      if (bus.we_o) begin we_k = k; wpc = bus.wpc_o; inst = bus.inst_o; break; end
      @(negedge clk);
    end
    bus.miss_i = 1'b0;
    checks++; if (we_k !== 10) begin errors++; $display("FAIL flush_we_cycle got=%0d exp=10", we_k); end
    checks++; if (wpc !== 32'h2000 || inst !== 32'h00500093) begin errors++; $display("FAIL flush_refill got wpc=%h inst=%h exp 00002000/00500093", wpc, inst); end
    @(negedge clk);
  endtask

  task automatic test_flush_write();
`ifdef ICACHE_REFILL_STATS_EN
    logic [31:0] rf0;
    rf0 = refill_cnt;
`endif
    bus.miss_pc_i = 32'h1000;
    bus.miss_i    = 1'b1;
    for (int k = 0; k < 6; k++) @(negedge clk);
    bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.we_o !== 1'b0 || bus.done_o !== 1'b0) begin errors++; $display("FAIL fwrite_pulse got we=%b done=%b exp 0/0", bus.we_o, bus.done_o); end
    bus.flush_i = 1'b0; bus.miss_i = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.we_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL fwrite_after got we=%b req=%b exp 0/0", bus.we_o, bus.mem_req_o); end
`ifdef ICACHE_REFILL_STATS_EN
    checks++; if (refill_cnt !== rf0) begin errors++; $display("FAIL fwrite_refills got=%0d exp=%0d", refill_cnt, rf0); end
`endif
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'hFFFF_FFFE; exp_addr[1] = 32'hFFFF_FFFF; exp_addr[2] = 32'h0; exp_addr[3] = 32'h1;
    bus.miss_pc_i = 32'hFFFF_FFFE;
    bus.miss_i    = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      #1;
      if (k >= 1 && k <= 4) begin
        checks++; if (bus.mem_addr_o !== exp_addr[k - 1]) begin errors++; $display("FAIL wrap_addr k=%0d got=%h exp=%h", k, bus.mem_addr_o, exp_addr[k - 1]); end
      end
      if (k == 6) begin
        checks++; if (bus.done_o !== 1'b1 || bus.inst_o !== 32'h563412B7 || bus.wpc_o !== 32'hFFFF_FFFE) begin
          errors++; $display("FAIL wrap_fill got done=%b inst=%h wpc=%h exp 1/563412b7/fffffffe", bus.done_o, bus.inst_o, bus.wpc_o);
        end
      end
      if (k < 6) @(negedge clk);
    end
    bus.miss_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    int pulses = 0;
    bus.miss_pc_i = 32'h1000;
    bus.miss_i    = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; bus.miss_i = 1'b0;
    @(negedge clk); #1;
    checks++; if ({bus.mem_req_o, bus.we_o, bus.done_o} !== 3'b000 || bus.mem_addr_o !== 32'h0) begin
      errors++; $display("FAIL rst_mid_ctrl got req=%b we=%b done=%b addr=%h exp all 0", bus.mem_req_o, bus.we_o, bus.done_o, bus.mem_addr_o);
    end
    checks++; if ({bus.wpc_o, bus.winst_o, bus.inst_o} !== 96'h0) begin errors++; $display("FAIL rst_mid_fill got=%h/%h/%h exp=0", bus.wpc_o, bus.winst_o, bus.inst_o); end
`ifdef ICACHE_REFILL_STATS_EN
    checks++; if ({refill_cnt, stall_cnt} !== 64'h0) begin errors++; $display("FAIL rst_mid_stats got=%0d/%0d exp=0/0", refill_cnt, stall_cnt); end
`endif
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (bus.we_o || bus.mem_req_o) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_quiet got=%0d active cycles exp=0", pulses); end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    bus.miss_i = 1'b0; bus.miss_pc_i = '0; bus.flush_i = 1'b0; bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    test_reset();
    test_continuous();
    test_grant_gap();
    test_rdy_stall();
    test_flush_fetch();
    test_flush_write();
    test_wrap();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Writer side of the instruction cache. On a fetch miss it reads the instruction byte-by-byte from the memory controller, assembles a 32-bit word, and issues a one-cycle cache fill write.
- It also returns the word directly to the fetch stage.
- Sits between IF and the memory arbiter; its fill port drives the cache's we/wpc/winst inputs.

Parameters:
- ADDR_W, 32, instruction address width
- INST_BYTES, 4, bytes per instruction fetched per refill
- CNT_W, 3, width of byte issue/receive counters (must hold 0..INST_BYTES)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; low = freeze all state
- miss_i  in  1  IF reports cache miss for miss_pc_i (level, held until done_o or flush_i)
- miss_pc_i  in  ADDR_W  address of missing instruction, word aligned
- flush_i  in  1  branch redirect; abort current refill
- mem_req_o  out  1  byte read request to arbiter
- mem_addr_o  out  ADDR_W  byte address of current request
- mem_gnt_i  in  1  arbiter accepted request this cycle
- mem_din_i  in  8  read data, valid exactly one cycle after a granted request
- we_o  out  1  cache fill write strobe (one-cycle pulse)
- wpc_o  out  ADDR_W  fill address
- winst_o  out  32  fill data
- done_o  out  1  one-cycle pulse to IF, coincident with we_o
- inst_o  out  32  assembled instruction, valid when done_o

Behaviour:
- Reset: state IDLE; mem_req_o, we_o, done_o = 0; mem_addr_o, wpc_o, winst_o, inst_o = 0; counters = 0; pending = 0.
- States:
  - IDLE: if miss_i && !flush_i, latch base = miss_pc_i, clear counters, go to FETCH.
  - FETCH: mem_req_o = (issued < INST_BYTES); mem_addr_o = base + issued.
    - Each cycle mem_gnt_i && mem_req_o: issued++ and pending is set for the next cycle.
    - Each cycle pending: mem_din_i is written into byte lane recv (little-endian: byte k -> bits 8k+7:8k), then recv++.
    - When recv reaches INST_BYTES, go to WRITE.
  - WRITE: one cycle with we_o = done_o = 1; wpc_o = base; winst_o = inst_o = assembled word. Then go to IDLE.
- Pipelining: requests are issued back-to-back. With continuous grant, a refill takes 1 (accept miss) + 4 (issue) + 1 (last data) + 1 (WRITE) = 7 cycles from miss_i to done_o. Gaps in mem_gnt_i stretch this 1:1.
- mem_req_o is combinational from state/counter and must not depend on mem_gnt_i.
- Flush: flush_i in any state returns to IDLE next cycle, clears pending and counters, and suppresses we_o/done_o.
  - A byte granted in the flush cycle still returns; it is discarded because pending is cleared.
  - flush_i in WRITE cancels the write.
  - flush_i with miss_i in the same cycle: flush wins; the miss is sampled the following cycle.
- rdy low: all registers hold and mem_req_o = 0. A grant cannot occur, and data already pending is captured only once rdy returns; the arbiter must hold mem_din_i while rdy is low.
- miss_i dropping mid-refill without flush_i: the refill completes and fills the cache, but done_o is still pulsed and ignored by IF.
- Address arithmetic wraps modulo 2^ADDR_W.
- rst mid-refill: immediate return to IDLE with reset values; no fill write.

Optional Feature:
- Macro ICACHE_REFILL_STATS_EN.
- Defined: adds outputs refill_cnt_o[31:0] (increments on each we_o) and stall_cnt_o[31:0] (increments each cycle in FETCH with mem_req_o && !mem_gnt_i). Both reset to 0 and wrap on overflow.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared defines: ZeroWord, InstAddrBus, InstBus, the INST_BYTES constant, and the state encodings IDLE/FETCH/WRITE (2-bit).
- One natural sub-module: refill_byte_assembler, which writes each incoming byte into its lane (by receive index) and outputs the 32-bit word; it has clear/enable inputs.
- The FSM and counters stay in the top module.

Test Plan:
- Continuous grant, miss_pc_i=0x00001000, bytes 0x13,0x05,0x10,0x00 -> mem_addr_o 0x1000..0x1003 on consecutive cycles; we_o/done_o pulse at cycle 7 with wpc_o=0x1000, winst_o=inst_o=0x00100513.
- Grant withheld 3 cycles after the first byte -> done_o delayed by exactly 3 cycles; same data; stall_cnt_o=3 with ICACHE_REFILL_STATS_EN.
- flush_i asserted the cycle after the second grant, then a new miss at 0x2000 -> no write for 0x1000; the stale byte is ignored; the refill at 0x2000 completes with the correct word.
- flush_i in WRITE cycle -> we_o and done_o remain 0; refill_cnt_o unchanged.
- rdy low for 2 cycles mid-FETCH -> mem_req_o=0 and state held; completion shifted by 2 cycles; word correct.
- rst asserted mid-FETCH -> next cycle all outputs 0 and state IDLE; no we_o pulse afterwards without a new miss.
